mem_sum_scheduler: RTL and testbench

//  8x8 register file shared between a host port (we/re/addr/din) and an internal

---
 rtl/mem_sum_scheduler.sv | 101 ++++++++++
 tb/tb_mem_sum_scheduler.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mem_sum_scheduler.sv
// mem_sum_scheduler: 8-entry register file shared by a host port and a summation engine.
// Define SUM_SATURATE_EN to make the accumulator clamp at all-ones on carry instead of wrapping.
module mem_sum_scheduler #(
  parameter int DW        = 8,
  parameter int AW        = 3,
  parameter int MAX_STALL = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [DW-1:0] din,
  input  logic          re,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   len,
  output logic [DW-1:0] dout,
  output logic          rd_valid,
  output logic          host_stall,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] ans,
  output logic          ovf
);
  localparam int DEPTH = 1 << AW;
  localparam int SW    = $clog2(MAX_STALL + 2);
  typedef enum logic [1:0] {S_IDLE, S_RD, S_ACC, S_DONE} state_t;
  state_t        r_state, w_next;
  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_base;
  logic [AW:0]   r_len, r_idx;
  logic [DW-1:0] r_data;
  logic [SW-1:0] r_stall_cnt;
  logic          w_host_req, w_eng_grant, w_host_grant, w_host_rd;
  logic [AW-1:0] w_eng_addr;
  logic [AW:0]   w_idx_nxt;
  logic [DW:0]   w_sum;
  logic [DW-1:0] w_acc;
  assign w_host_req   = we | re;
  assign w_eng_grant  = (r_state == S_RD) && (!w_host_req || r_stall_cnt == SW'(MAX_STALL));
  assign w_host_grant = w_host_req & ~w_eng_grant;
  assign w_host_rd    = w_host_grant & re & ~we;
  assign host_stall   = w_host_req & w_eng_grant;
  assign w_eng_addr   = r_base + r_idx[AW-1:0];
  assign w_idx_nxt    = r_idx + 1'b1;
  assign w_sum        = {1'b0, ans} + {1'b0, r_data};
  assign busy         = (r_state == S_RD) || (r_state == S_ACC);
  assign done         = (r_state == S_DONE);
`ifdef SUM_SATURATE_EN
  assign w_acc = w_sum[DW] ? '1 : w_sum[DW-1:0];
`else
  assign w_acc = w_sum[DW-1:0];
`endif
  always_ff @(posedge clk)
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = (len == '0) ? S_DONE : S_RD;
      S_RD:    if (w_eng_grant) w_next = S_ACC;
      S_ACC:   w_next = (w_idx_nxt == r_len) ? S_DONE : S_RD;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    else if (w_host_grant & we) r_mem[addr] <= din;
  // Engine snapshot uses the pre-edge memory value, so a same-edge host write is not seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout        <= '0;
      rd_valid    <= 1'b0;
      ans         <= '0;
      ovf         <= 1'b0;
      r_base      <= '0;
      r_len       <= '0;
      r_idx       <= '0;
      r_data      <= '0;
      r_stall_cnt <= '0;
    end else begin
      rd_valid <= w_host_rd;
      if (w_host_rd) dout <= r_mem[addr];
      if (w_eng_grant) r_data <= r_mem[w_eng_addr];
      r_stall_cnt <= (w_eng_grant || r_state == S_IDLE) ? '0 :
                     (r_state == S_RD && w_host_req) ? r_stall_cnt + 1'b1 : r_stall_cnt;
      if (r_state == S_IDLE && start) begin
        r_base <= base;
        r_len  <= len;
        r_idx  <= '0;
        ans    <= '0;
        ovf    <= 1'b0;
      end
      if (r_state == S_ACC) begin
        ans   <= w_acc;
        ovf   <= ovf | w_sum[DW];
        r_idx <= w_idx_nxt;
      end
    end
  end
endmodule

// File: tb/tb_mem_sum_scheduler.sv
// tb_mem_sum_scheduler: scoreboard bench for host reads and summation results.
module tb_mem_sum_scheduler;
  logic       clk = 0, rst = 1;
  logic [2:0] addr = 0, base = 0;
  logic       we = 0, re = 0, start = 0;
  logic [7:0] din = 0;
  logic [3:0] len = 0;
  logic [7:0] dout, ans;
  logic       rd_valid, host_stall, busy, done, ovf;
  int         checks = 0, errors = 0;
  logic [7:0] model [8];
  logic [7:0] rq [$];
  logic [8:0] sq [$];

  mem_sum_scheduler dut (
    .clk(clk), .rst(rst), .addr(addr), .we(we), .din(din), .re(re),
    .start(start), .base(base), .len(len), .dout(dout), .rd_valid(rd_valid),
    .host_stall(host_stall), .busy(busy), .done(done), .ans(ans), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) if (!rst) begin
    if (rd_valid) begin
      if (rq.size() > 0) check("rd_data", dout, rq.pop_front());
      else check("rd_valid_unexp", rd_valid, 0);
    end
    if (done) begin
      if (sq.size() > 0) begin
        logic [8:0] e;
        e = sq.pop_front();
        check("ans", ans, e[7:0]);
        check("ovf", ovf, e[8]);
      end else check("done_unexp", done, 0);
    end
    if ((we | re) && !host_stall) begin
      if (we) model[addr] = din;
      else rq.push_back(model[addr]);
    end
  end

  task automatic host_op(input bit w, input bit r, input logic [2:0] a, input logic [7:0] d);
    we = w; re = r; addr = a; din = d;
    @(posedge clk); #1;
    we = 0; re = 0;
  endtask

  task automatic run_sum(input logic [2:0] b, input logic [3:0] l, input int exp_lat,
                         input bit hold_re, input bit inj);
    logic [8:0] s;
    logic [7:0] acc;
    bit         o;
    int         n, bad;
    acc = 0; o = 0;
    for (int i = 0; i < l; i++) begin
      s = {1'b0, acc} + {1'b0, model[(b + i) % 8]};
      if (s[8]) o = 1;
`ifdef SUM_SATURATE_EN
      acc = s[8] ? 8'hff : s[7:0];
`else
      acc = s[7:0];
`endif
    end
    sq.push_back({o, acc});
    start = 1; base = b; len = l;
    if (hold_re) begin re = 1; addr = 7; end
    @(posedge clk); #1;
    start = 0;
    n = 0; bad = 0;
    do begin
      @(negedge clk);
      n++;
      if (hold_re && (host_stall != (n % 4 == 3))) bad++;
      if (inj && n == 3) begin start = 1; base = 3; len = 1; end
      if (inj && n == 4) start = 0;
    end while (!done && n < 400);
    check("latency", n, exp_lat);
    if (hold_re) check("stall_pos", bad, 0);
    @(posedge clk); #1;
    re = 0;
    @(negedge clk);
    check("busy_after", busy, 0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) model[i] = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_dout", dout, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ans", ans, 0);
    check("rst_ovf", ovf, 0);
    check("rst_stall", host_stall, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) host_op(1, 0, 3'(i), 8'(10 * (i + 1)));
    for (int i = 0; i < 6; i++) host_op(0, 1, 3'(i), 0);
    host_op(1, 1, 7, 8'd99);
    host_op(0, 0, 0, 0);
    run_sum(0, 6, 13, 0, 0);
    run_sum(0, 6, 13, 0, 1);
    host_op(1, 0, 6, 1);
    host_op(1, 0, 7, 2);
    host_op(1, 0, 0, 3);
    host_op(1, 0, 1, 4);
    run_sum(6, 4, 9, 0, 0);
    host_op(1, 0, 0, 200);
    host_op(1, 0, 1, 100);
    run_sum(0, 2, 5, 0, 0);
    host_op(1, 0, 0, 10);
    host_op(1, 0, 1, 20);
    run_sum(0, 6, 25, 1, 0);
    run_sum(5, 0, 1, 0, 0);
    @(posedge clk); #1;
    start = 1; base = 0; len = 6;
    @(posedge clk); #1;
    start = 0;
    repeat (6) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    rst = 0;
    for (int i = 0; i < 8; i++) model[i] = 0;
    rq.delete();
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ans", ans, 0);
    check("mid_rst_ovf", ovf, 0);
    check("mid_rst_dout", dout, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 8; i += 3) host_op(0, 1, 3'(i), 0);
    repeat (20) @(posedge clk);
    #1;
    check("rq_left", rq.size(), 0);
    check("sq_left", sq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
